// File: rtl/dmio_param_if.sv
// dmio_param_if: load/store bus between the datapath core (master) and dmio_param (slave).
interface dmio_param_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
);
    logic [ADDR_W-1:0] direccion;
    logic [DATA_W-1:0] dataWrite;
    logic              memWr;
    logic              memRd;
    logic [DATA_W-1:0] dataRead;
    logic              dataReadValid;

    modport master (
        output direccion, dataWrite, memWr, memRd,
        input  dataRead, dataReadValid
    );

    modport slave (
        input  direccion, dataWrite, memWr, memRd,
        output dataRead, dataReadValid
    );
endinterface

// File: rtl/dmio_param.sv
// dmio_param: data-memory / memory-mapped IO unit for the load/store stage.
// direccion[MEM_AW] selects RAM (0) or the IO bank (1); loads have a fixed
// 1-cycle latency with a valid strobe.
// Optional build macro: DMIO_CHANGE_IRQ_EN adds the IRQ mask register (idx 10)
// and the registered irq output.
module dmio_param #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64,
    parameter int MEM_AW = 12,
    parameter int IO_CH  = 1
) (
    input  logic               clk,
    input  logic               reset,
    dmio_param_if.slave        bus,
    input  logic [8*IO_CH-1:0] sw,
`ifdef DMIO_CHANGE_IRQ_EN
    output logic               irq,
`endif
    output logic [8*IO_CH-1:0] lecturaLED
);
    localparam int SW_W = 8 * IO_CH;

    logic [DATA_W-1:0] r_mem [2**MEM_AW];

    logic              w_io_sel;
    logic [MEM_AW-1:0] w_ram_addr;
    logic [3:0]        w_idx;
    logic              w_ram_wr;
    logic              w_io_wr;
    logic [SW_W-1:0]   w_chg_clr;
    logic [DATA_W-1:0] w_io_rd;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_unused;

    logic [SW_W-1:0]   r_sync_p0;
    logic [SW_W-1:0]   r_sync_p1;
    logic [SW_W-1:0]   r_sw_q;
    logic [SW_W-1:0]   r_chg;
    logic [SW_W-1:0]   r_led;
    logic [DATA_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_rd_data_p1;
    logic              r_rd_vld_p1;
`ifdef DMIO_CHANGE_IRQ_EN
    logic [SW_W-1:0]   r_mask;
    logic              r_irq;
`endif

    // Address decode; bits above MEM_AW alias onto the same locations.
    assign w_io_sel   = bus.direccion[MEM_AW];
    assign w_ram_addr = bus.direccion[MEM_AW-1:0];
    assign w_idx      = bus.direccion[3:0];
    assign w_ram_wr   = bus.memWr & ~w_io_sel;
    assign w_io_wr    = bus.memWr & w_io_sel;
    assign w_chg_clr  = (w_io_wr && w_idx == 4'd9) ? bus.dataWrite[SW_W-1:0] : '0;
    assign w_unused   = ^bus.direccion[ADDR_W-1:MEM_AW+1];

    // Word RAM: contents are never reset.
    always_ff @(posedge clk) begin
        if (w_ram_wr) r_mem[w_ram_addr] <= bus.dataWrite;
    end

    // Switch synchroniser, registered switch value and sticky change flags (set beats clear).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync_p0 <= '0;
            r_sync_p1 <= '0;
            r_sw_q    <= '0;
            r_chg     <= '0;
        end else begin
            r_sync_p0 <= sw;
            r_sync_p1 <= r_sync_p0;
            r_sw_q    <= r_sync_p1;
            r_chg     <= (r_chg & ~w_chg_clr) | (r_sync_p1 ^ r_sw_q);
        end
    end

    // LED channel registers, written from the low byte of the store data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_led <= '0;
        end else begin
            for (int i = 0; i < IO_CH; i++) begin
                if (w_io_wr && w_idx == 4'(i)) r_led[i*8 +: 8] <= bus.dataWrite[7:0];
            end
        end
    end

    // Free-running cycle counter, wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_cnt <= '0;
        else       r_cnt <= r_cnt + DATA_W'(1);
    end

`ifdef DMIO_CHANGE_IRQ_EN
    // IRQ mask register and registered interrupt from masked change flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mask <= '0;
            r_irq  <= 1'b0;
        end else begin
            if (w_io_wr && w_idx == 4'd10) r_mask <= bus.dataWrite[SW_W-1:0];
            r_irq <= |(r_chg & r_mask);
        end
    end

    assign irq = r_irq;
`endif

    // IO read mux; unmapped indices read as zero.
    always_comb begin
        w_io_rd = '0;
        for (int i = 0; i < IO_CH; i++) begin
            if (w_idx == 4'(i)) w_io_rd = DATA_W'(r_led[i*8 +: 8]);
        end
        case (w_idx)
            4'd8:    w_io_rd = DATA_W'(r_sw_q);
            4'd9:    w_io_rd = DATA_W'(r_chg);
`ifdef DMIO_CHANGE_IRQ_EN
            4'd10:   w_io_rd = DATA_W'(r_mask);
`endif
            4'd15:   w_io_rd = r_cnt;
            default: ;
        endcase
    end

    assign w_rd_data = w_io_sel ? w_io_rd : r_mem[w_ram_addr];

    // Load register: captures pre-write data, so a same-cycle store reads the old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_vld_p1  <= 1'b0;
            r_rd_data_p1 <= '0;
        end else begin
            r_rd_vld_p1 <= bus.memRd;
            if (bus.memRd) r_rd_data_p1 <= w_rd_data;
        end
    end

    assign bus.dataRead      = r_rd_data_p1;
    assign bus.dataReadValid = r_rd_vld_p1;
    assign lecturaLED        = r_led;
endmodule

// File: tb/tb_dmio_param.sv
// tb_dmio_param: randomized self-checking bench for dmio_param (IO_CH=2).
module tb_dmio_param;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sw;
    logic [15:0] lecturaLED;
`ifdef DMIO_CHANGE_IRQ_EN
    logic        irq;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] ram_m [int];
    int          keys[$];
    logic [7:0]  led_m [2];

    dmio_param_if #(.DATA_W(64), .ADDR_W(64)) bus ();

    dmio_param #(.DATA_W(64), .ADDR_W(64), .MEM_AW(12), .IO_CH(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .sw         (sw),
`ifdef DMIO_CHANGE_IRQ_EN
        .irq        (irq),
`endif
        .lecturaLED (lecturaLED)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [63:0] a, input logic [63:0] d);
        bus.direccion = a;
        bus.dataWrite = d;
        bus.memWr     = 1'b1;
        @(posedge clk);
        #1;
        bus.memWr     = 1'b0;
    endtask

    task automatic rd(input logic [63:0] a, output logic [63:0] d, output logic v);
        bus.direccion = a;
        bus.memRd     = 1'b1;
        @(posedge clk);
        #1;
        d = bus.dataRead;
        v = bus.dataReadValid;
        bus.memRd = 1'b0;
    endtask

    function automatic logic [63:0] ram_alias(input int idx);
        logic [63:0] a;
        a = {$urandom(), $urandom()};
        a[12] = 1'b0;
        a[11:0] = 12'(idx);
        return a;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        sw = '0;
        bus.direccion = '0;
        bus.dataWrite = '0;
        bus.memWr = 1'b0;
        bus.memRd = 1'b1;
        idle(3);
        n_checks++;
        if (bus.dataReadValid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b expected 0", bus.dataReadValid);
        end
        n_checks++;
        if (bus.dataRead !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0", bus.dataRead);
        end
        n_checks++;
        if (lecturaLED !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_led: got %h expected 0", lecturaLED);
        end
`ifdef DMIO_CHANGE_IRQ_EN
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_irq: got %b expected 0", irq);
        end
`endif
        bus.memRd = 1'b0;
        reset = 1'b0;
        led_m[0] = 8'd0;
        led_m[1] = 8'd0;
        idle(1);
    endtask

    task automatic test_ram_basic();
        logic [63:0] d;
        logic v;
        wr(64'h005, 64'hDEADBEEF_00000001);
        ram_m[5] = 64'hDEADBEEF_00000001;
        rd(64'h005, d, v);
        n_checks++;
        if (v !== 1'b1 || d !== 64'hDEADBEEF_00000001) begin
            n_fail++;
            $display("FAIL ram_read: got v=%b d=%h expected v=1 d=deadbeef00000001", v, d);
        end
        idle(1);
        n_checks++;
        if (bus.dataReadValid !== 1'b0 || bus.dataRead !== 64'hDEADBEEF_00000001) begin
            n_fail++;
            $display("FAIL ram_hold: got v=%b d=%h expected v=0 d=deadbeef00000001",
                     bus.dataReadValid, bus.dataRead);
        end
        rd(64'h2005, d, v);
        n_checks++;
        if (v !== 1'b1 || d !== 64'hDEADBEEF_00000001) begin
            n_fail++;
            $display("FAIL ram_alias: got v=%b d=%h expected v=1 d=deadbeef00000001", v, d);
        end
    endtask

    task automatic test_read_before_write();
        logic [63:0] d;
        logic v;
        wr(64'h010, 64'h11);
        bus.direccion = 64'h010;
        bus.dataWrite = 64'h22;
        bus.memWr = 1'b1;
        bus.memRd = 1'b1;
        @(posedge clk);
        #1;
        bus.memWr = 1'b0;
        bus.memRd = 1'b0;
        n_checks++;
        if (bus.dataRead !== 64'h11) begin
            n_fail++;
            $display("FAIL rbw_old: got %h expected 11", bus.dataRead);
        end
        ram_m[16] = 64'h22;
        rd(64'h010, d, v);
        n_checks++;
        if (d !== 64'h22) begin
            n_fail++;
            $display("FAIL rbw_new: got %h expected 22", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] d;
        logic [63:0] last;
        logic v;
        int idx;
        int op;
        for (int i = 0; i < 8; i++) begin
            idx = int'($urandom_range(32, 4095));
            d = {$urandom(), $urandom()};
            wr(ram_alias(idx), d);
            ram_m[idx] = d;
            keys.push_back(idx);
        end
        last = '0;
        for (int i = 0; i < 8; i++) begin
            bus.direccion = ram_alias(keys[i]);
            bus.memRd = 1'b1;
            @(posedge clk);
            #1;
            last = ram_m[keys[i]];
            n_checks++;
            if (bus.dataReadValid !== 1'b1 || bus.dataRead !== last) begin
                n_fail++;
                $display("FAIL b2b_read[%0d]: got v=%b d=%h expected v=1 d=%h",
                         i, bus.dataReadValid, bus.dataRead, last);
            end
        end
        bus.memRd = 1'b0;
        idle(1);
        n_checks++;
        if (bus.dataReadValid !== 1'b0 || bus.dataRead !== last) begin
            n_fail++;
            $display("FAIL b2b_end: got v=%b d=%h expected v=0 d=%h",
                     bus.dataReadValid, bus.dataRead, last);
        end
        for (int i = 0; i < 30; i++) begin
            op = int'($urandom_range(0, 2));
            idx = keys[$urandom_range(0, keys.size() - 1)];
            if (op == 0) begin
                idx = int'($urandom_range(32, 4095));
                d = {$urandom(), $urandom()};
                wr(ram_alias(idx), d);
                if (!ram_m.exists(idx)) keys.push_back(idx);
                ram_m[idx] = d;
            end else if (op == 1) begin
                rd(ram_alias(idx), d, v);
                n_checks++;
                if (v !== 1'b1 || d !== ram_m[idx]) begin
                    n_fail++;
                    $display("FAIL mix_read[%0d]: got v=%b d=%h expected v=1 d=%h",
                             i, v, d, ram_m[idx]);
                end
            end else begin
                bus.direccion = ram_alias(idx);
                bus.dataWrite = {$urandom(), $urandom()};
                bus.memWr = 1'b1;
                bus.memRd = 1'b1;
                @(posedge clk);
                #1;
                bus.memWr = 1'b0;
                bus.memRd = 1'b0;
                n_checks++;
                if (bus.dataRead !== ram_m[idx]) begin
                    n_fail++;
                    $display("FAIL mix_rbw[%0d]: got %h expected %h", i, bus.dataRead, ram_m[idx]);
                end
                ram_m[idx] = bus.dataWrite;
            end
        end
    endtask

    task automatic test_led();
        logic [63:0] d;
        logic v;
        int ch;
        wr(64'h1000, 64'h1AB);
        wr(64'h1001, 64'h5C);
        led_m[0] = 8'hAB;
        led_m[1] = 8'h5C;
        n_checks++;
        if (lecturaLED !== 16'h5CAB) begin
            n_fail++;
            $display("FAIL led_out: got %h expected 5cab", lecturaLED);
        end
        rd(64'h1000, d, v);
        n_checks++;
        if (d !== 64'hAB) begin
            n_fail++;
            $display("FAIL led_read: got %h expected ab", d);
        end
        for (int i = 0; i < 6; i++) begin
            ch = int'($urandom_range(0, 1));
            d = {$urandom(), $urandom()};
            wr(64'h1000 + 64'(ch), d);
            led_m[ch] = d[7:0];
            rd(64'h1000 + 64'(ch), d, v);
            n_checks++;
            if (lecturaLED !== {led_m[1], led_m[0]} || d !== 64'(led_m[ch])) begin
                n_fail++;
                $display("FAIL led_rand[%0d]: got led=%h rd=%h expected led=%h rd=%h",
                         i, lecturaLED, d, {led_m[1], led_m[0]}, led_m[ch]);
            end
        end
        wr(64'h1003, 64'hFF);
        rd(64'h1003, d, v);
        n_checks++;
        if (d !== 64'd0 || lecturaLED !== {led_m[1], led_m[0]}) begin
            n_fail++;
            $display("FAIL io_unmapped: got rd=%h led=%h expected rd=0 led=%h",
                     d, lecturaLED, {led_m[1], led_m[0]});
        end
        wr(64'h100B, 64'hFF);
        rd(64'h100B, d, v);
        n_checks++;
        if (d !== 64'd0) begin
            n_fail++;
            $display("FAIL io_idx11: got %h expected 0", d);
        end
`ifndef DMIO_CHANGE_IRQ_EN
        wr(64'h100A, 64'hFF);
        rd(64'h100A, d, v);
        n_checks++;
        if (d !== 64'd0) begin
            n_fail++;
            $display("FAIL io_nomask: got %h expected 0", d);
        end
`endif
    endtask

    task automatic test_switch();
        logic [63:0] d;
        logic v;
        logic [15:0] old_sw;
        logic [15:0] new_sw;
        sw = 16'h0081;
        rd(64'h1008, d, v);
        n_checks++;
        if (d !== 64'd0) begin
            n_fail++;
            $display("FAIL sw_early: got %h expected 0", d);
        end
        idle(3);
        rd(64'h1008, d, v);
        n_checks++;
        if (d !== 64'h81) begin
            n_fail++;
            $display("FAIL sw_value: got %h expected 81", d);
        end
        rd(64'h1009, d, v);
        n_checks++;
        if (d !== 64'h81) begin
            n_fail++;
            $display("FAIL chg_set: got %h expected 81", d);
        end
        wr(64'h1009, 64'h01);
        rd(64'h1009, d, v);
        n_checks++;
        if (d !== 64'h80) begin
            n_fail++;
            $display("FAIL chg_w1c: got %h expected 80", d);
        end
        for (int k = 0; k < 8; k++) begin
            sw[0] = ~sw[0];
            bus.direccion = 64'h1009;
            bus.dataWrite = 64'h01;
            bus.memWr = (k == 4);
            @(posedge clk);
            #1;
        end
        bus.memWr = 1'b0;
        rd(64'h1009, d, v);
        n_checks++;
        if (d[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL chg_set_wins: got bit0=%b expected 1", d[0]);
        end
        idle(4);
        wr(64'h1009, 64'hFFFF);
        rd(64'h1009, d, v);
        n_checks++;
        if (d !== 64'd0) begin
            n_fail++;
            $display("FAIL chg_clear_all: got %h expected 0", d);
        end
        for (int i = 0; i < 6; i++) begin
            old_sw = sw;
            new_sw = 16'($urandom());
            wr(64'h1009, 64'hFFFF);
            sw = new_sw;
            idle(4);
            rd(64'h1008, d, v);
            n_checks++;
            if (d !== 64'(new_sw)) begin
                n_fail++;
                $display("FAIL sw_rand[%0d]: got %h expected %h", i, d, new_sw);
            end
            rd(64'h1009, d, v);
            n_checks++;
            if (d !== 64'(old_sw ^ new_sw)) begin
                n_fail++;
                $display("FAIL chg_rand[%0d]: got %h expected %h", i, d, old_sw ^ new_sw);
            end
        end
    endtask

    task automatic test_counter();
        logic [63:0] c1;
        logic [63:0] c2;
        logic v;
        rd(64'h100F, c1, v);
        idle(4);
        rd(64'h100F, c2, v);
        n_checks++;
        if (c2 - c1 !== 64'd5) begin
            n_fail++;
            $display("FAIL cnt_delta: got %0d expected 5", c2 - c1);
        end
        force dut.r_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.r_cnt;
        rd(64'h100F, c1, v);
        rd(64'h100F, c2, v);
        n_checks++;
        if (c1 !== 64'hFFFF_FFFF_FFFF_FFFF || c2 !== 64'd0) begin
            n_fail++;
            $display("FAIL cnt_wrap: got %h then %h expected ffffffffffffffff then 0", c1, c2);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [63:0] d;
        logic v;
        bus.direccion = 64'h1000;
        bus.memRd = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.dataReadValid !== 1'b0 || bus.dataRead !== 64'd0 || lecturaLED !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_mid: got v=%b d=%h led=%h expected v=0 d=0 led=0",
                     bus.dataReadValid, bus.dataRead, lecturaLED);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.dataReadValid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_drop: got v=%b expected 0", bus.dataReadValid);
        end
        bus.memRd = 1'b0;
        reset = 1'b0;
        led_m[0] = 8'd0;
        led_m[1] = 8'd0;
        rd(64'h100F, d, v);
        n_checks++;
        if (d !== 64'd0 || v !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_cnt0: got v=%b d=%h expected v=1 d=0", v, d);
        end
        rd(64'h100F, d, v);
        n_checks++;
        if (d !== 64'd1) begin
            n_fail++;
            $display("FAIL rst_cnt1: got %h expected 1", d);
        end
        rd(64'h005, d, v);
        n_checks++;
        if (d !== ram_m[5]) begin
            n_fail++;
            $display("FAIL rst_ram_kept: got %h expected %h", d, ram_m[5]);
        end
    endtask

`ifdef DMIO_CHANGE_IRQ_EN
    task automatic test_irq();
        logic [63:0] d;
        logic v;
        idle(4);
        wr(64'h1009, 64'hFFFF);
        wr(64'h100A, 64'h01);
        rd(64'h100A, d, v);
        n_checks++;
        if (d !== 64'h01 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_mask: got mask=%h irq=%b expected mask=1 irq=0", d, irq);
        end
        sw[1] = ~sw[1];
        idle(5);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_masked_off: got %b expected 0", irq);
        end
        sw[0] = ~sw[0];
        idle(5);
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_assert: got %b expected 1", irq);
        end
        wr(64'h1009, 64'h01);
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_hold: got %b expected 1", irq);
        end
        idle(1);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_clear: got %b expected 0", irq);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ram_basic();
        test_read_before_write();
        test_back_to_back();
        test_led();
        test_switch();
        test_counter();
        test_reset_mid_read();
`ifdef DMIO_CHANGE_IRQ_EN
        test_irq();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
